// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM state encoding, primary
// opcode constants and the default reset vector.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word offset of a conditional branch: sign-extended immediate scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: variable-latency req/ack handshake.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection for the retiring instruction:
// jump beats taken branch beats sequential.
module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_inst,
    input  logic        i_branch,
    input  logic        i_zero,
    input  logic        i_jump,
    output logic [31:0] o_target
);

    // The opcode field is decoded upstream; only the immediate/index fields matter here.
    logic [5:0] w_unused_opcode;
    assign w_unused_opcode = i_inst[31:26];

    // NOTE: o_target gets a default before any branch of the if-chain, so no latch is inferred.
    always_comb begin
        o_target = i_pc_plus4;
        if (i_jump) begin
            o_target = jump_target(i_pc_plus4, i_inst[25:0]);
        end else if (i_branch && i_zero) begin
            o_target = i_pc_plus4 + branch_offset(i_inst[15:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IDLE/FETCH/HOLD fetch FSM, captured
// instruction and retired-instruction counter.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    output logic [31:0]        inst,
    output logic               inst_valid,
    input  logic               inst_ready,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instret
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_instret;

    logic        w_capture;
    logic        w_retire;
    logic        w_imem_req;
    logic        w_inst_valid;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;

    next_pc u_next_pc (
        .i_pc_plus4 (w_pc_plus4),
        .i_inst     (r_inst),
        .i_branch   (branch),
        .i_zero     (zero),
        .i_jump     (jump),
        .o_target   (w_next_pc)
    );

    // Handshake outputs depend only on r_state; ack/ready only steer transitions.
    always_comb begin
        w_state_next = r_state;
        w_imem_req   = 1'b0;
        w_inst_valid = 1'b0;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem.imem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_inst_valid = 1'b1;
                if (inst_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0000_0000;
            r_instret <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_inst <= imem.imem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_next_pc;
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign imem.imem_req  = w_imem_req;
    assign imem.imem_addr = r_pc;
    assign inst           = r_inst;
    assign inst_valid     = w_inst_valid;
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign instret        = r_instret;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle MIPS processor. It holds the PC, requests instruction words from instruction memory over a variable-latency req/ack handshake, and presents the captured word as `inst` to the control decoder and datapath. It takes the branch/jump decision of the current instruction on retire and computes the next PC from it. It also keeps a retired-instruction counter.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset (word-aligned)
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  32  fetch address (= pc)
- `imem_ack`  in  1  read data valid this cycle
- `imem_rdata`  in  32  instruction word, sampled when `imem_ack`
- `inst`  out  32  captured instruction to control/datapath
- `inst_valid`  out  1  `inst` holds a fetched, unretired instruction
- `inst_ready`  in  1  datapath retires current instruction this cycle
- `branch`  in  1  decoded branch flag for `inst`
- `zero`  in  1  ALU zero flag for `inst`
- `jump`  in  1  decoded jump flag for `inst`
- `pc`  out  32  address of `inst`
- `pc_plus4`  out  32  pc + 4 (modulo 2^32)
- `instret`  out  32  retired-instruction count

## Operation
- FSM states:
  - IDLE (reset state): advances to FETCH unconditionally next cycle.
  - FETCH: `imem_req`=1, `imem_addr`=pc. On `imem_ack`: `inst`<=`imem_rdata`, go to HOLD.
  - HOLD: `inst_valid`=1. On `inst_ready`: pc<=next_pc, `instret`+=1, go to FETCH.
- next_pc, evaluated in HOLD with `inst_ready`, priority order:
  - `jump` → {pc_plus4[31:28], inst[25:0], 2'b00}
  - `branch & zero` → pc_plus4 + (sign_extend(inst[15:0]) << 2), 32-bit, wraps
  - else → pc_plus4
- Flags are sampled only in the retire cycle; their values at other times are ignored, including X.
- `imem_ack` is ignored outside FETCH. `inst_ready` is ignored outside HOLD.
- `inst` is stable for the whole of HOLD.
- `instret` wraps 32'hFFFF_FFFF → 0.
- pc at 32'hFFFF_FFFC: pc_plus4 = 0.

## Timing
- Reset values:
  - state IDLE; pc = `RESET_PC`; `inst` = 0; `instret` = 0
  - `imem_req` = 0; `inst_valid` = 0
- First `imem_req` is the second cycle after `reset` deasserts.
- `imem_req` and `inst_valid` are decoded from registered state only, never from inputs.
- Ack in the same cycle as req: `inst_valid` is high the next cycle.
- Best-case throughput is 2 cycles per instruction (FETCH 1 cycle + HOLD 1 cycle).
- Wait states: `imem_req` and `imem_addr` stay constant until `imem_ack`.
- Retire cycle: new pc and `imem_req` appear the cycle after `inst_ready`.
- Reset mid-operation: reset wins over everything. Any outstanding request is abandoned. An ack in the reset cycle is dropped, and no `instret` increment occurs.

## Structure
- Shared package `mips_pkg` holds:
  - state enum (IDLE/FETCH/HOLD)
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_ORI`, `OP_J`)
  - default `RESET_PC`
- One combinational sub-module, `next_pc`, takes inputs pc_plus4, inst, branch, zero, jump and outputs the target. The FSM, PC register and counter stay in `fetch_unit`.

## Test plan
- Sequential fetch: reset with RESET_PC=0, ack immediately, `inst_ready`=1 in HOLD → `imem_addr` 0, 4, 8 on successive FETCH cycles; `instret`=3 after three retires.
- Wait states: ack delayed 3 cycles → `imem_req` high for 4 cycles with addr constant; `inst_valid` low throughout; `inst`=`imem_rdata` on the ack cycle.
- beq:
  - pc=0x10, inst=0x1000_0003, branch=1, zero=1 → next addr 0x20.
  - Same inst with zero=0 → next addr 0x14.
  - inst=0x1000_FFFF taken → next addr 0x10.
- Jump: pc=0x0040_0000, inst=0x0810_0004, jump=1 (also branch=1, zero=1) → next addr 0x0040_0010 (jump wins).
- Wrap and reset mid-op:
  - pc=0xFFFF_FFFC sequential retire → next addr 0.
  - Reset asserted in FETCH with ack in the same cycle → `inst_valid` stays 0; pc=RESET_PC; `instret` unchanged at 0.
- Hold stability: `inst_ready` low for 5 cycles in HOLD → `inst`, pc and `instret` constant; an `imem_ack` pulse in HOLD is ignored.
